lsu_mem_master: RTL
===================

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 Parameter MAX_WAIT, default 15, SHALL set the bus timeout in cycles spent in REQ plus WAIT; legal range 2..255.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 req_valid  in  1  MEM-stage instruction valid.
REQ-005 op  in  6  instruction bits [31:26]: LB 100000, LBU 100100, LH 100001, LHU 100101, LW 100011, SB 101000, SH 101001, SW 101011.
REQ-006 addr  in  32  effective byte address; wdata  in  32  store source register.
REQ-007 stall  out  1  freeze the pipeline; done  out  1  one-cycle completion pulse; rdata  out  32  extended load result.
REQ-008 exc_misalign  out  1  misaligned access flag; exc_bus  out  1  bus timeout flag.
REQ-009 mem_req  out  1, mem_we  out  1, mem_be  out  4, mem_addr  out  32, mem_wdata  out  32  request channel to data memory.
REQ-010 mem_gnt  in  1  request accepted; mem_rvalid  in  1  response or write ack; mem_rdata  in  32  read word.

Function
REQ-011 Only the 8 listed opcodes SHALL be memory ops; req_valid with any other op SHALL be ignored (no stall, no request).
REQ-012 FSM states: IDLE, REQ, WAIT, RESP.
REQ-013 IDLE: a valid memory op SHALL latch op, addr and wdata, assert stall combinationally in that cycle, and go to REQ.
REQ-014 REQ: mem_req SHALL be 1 with stable mem_addr, mem_we, mem_be and mem_wdata until the cycle mem_gnt=1; then go to WAIT.
REQ-015 WAIT: mem_rvalid=1 SHALL capture the formatted result and go to RESP; mem_rvalid in IDLE, REQ or RESP SHALL be ignored.
REQ-016 RESP: done=1, stall=0 for exactly one cycle, then IDLE; req_valid in RESP SHALL NOT start a new access.
REQ-017 stall SHALL be 1 in REQ and WAIT, and in IDLE when REQ-013 fires; otherwise 0.
REQ-018 mem_addr SHALL be {addr[31:2],2'b00}; mem_we=1 for stores only.
REQ-019 Byte enables: loads 1111; SW 1111; SH 0011 if addr[1]=0, else 1100; SB 0001 shifted left by addr[1:0].
REQ-020 Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-021 Byte and halfword lanes SHALL be selected from mem_rdata using addr[1:0] and addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-022 rdata SHALL hold its value from RESP until the next capture; stores SHALL load rdata with 0.
REQ-023 A cycle counter SHALL clear on entry to REQ and count in REQ and WAIT; reaching MAX_WAIT SHALL drop mem_req, set exc_bus=1, set rdata=0, and go to RESP.
REQ-024 exc_bus and exc_misalign SHALL be valid only while done=1 and 0 otherwise.
REQ-025 Ack latency: 1 cycle from latch to mem_req; minimum 4 cycles from latch to done (gnt in first REQ cycle, rvalid next cycle).

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE and set every output, the counter and latched fields to 0.
REQ-027 An access in flight at reset SHALL be abandoned and its later mem_rvalid ignored.

Configuration
REQ-028 With LSU_MISALIGN_EXC_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL skip REQ/WAIT, never assert mem_req, and go directly to RESP with exc_misalign=1 and rdata=0.
REQ-029 Without LSU_MISALIGN_EXC_EN: exc_misalign SHALL be tied 0; addr[0] is ignored for halfwords and addr[1:0] is ignored for words; the access proceeds normally.

Verification
REQ-030 LB addr 0x1003, mem_rdata 0x80FF_1234, gnt and rvalid immediate -> mem_be 1111, mem_addr 0x1000, rdata 0xFFFFFF80, done 4 cycles after latch.
REQ-031 SH addr 0x2002, wdata 0x0000_ABCD -> mem_we 1, mem_be 1100, mem_wdata 0xABCDABCD, rdata 0.
REQ-032 LHU addr 0x10, gnt delayed 3 cycles -> mem_req held 4 cycles with stable fields, stall 1 throughout, rdata = zero-extended mem_rdata[15:0].
REQ-033 LW, MAX_WAIT=15, mem_rvalid never asserted -> exc_bus=1 with done 15 cycles after entering REQ, rdata 0, mem_req low after timeout.
REQ-034 LW addr 0x6 -> with LSU_MISALIGN_EXC_EN: no mem_req, exc_misalign=1, done 2 cycles after latch; without it: mem_addr 0x4, normal completion.
REQ-035 rst_n low during WAIT, then rvalid after release -> all outputs 0, state IDLE, no done pulse.

Source files
------------

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_master
// Description : MEM-stage load/store unit that turns one decoded memory
//               instruction into a single request/response transaction on
//               the data-memory channel. It forms byte enables and store-lane
//               data, formats load results with sign or zero extension,
//               freezes the pipeline while the access is in flight, and
//               reports a bus timeout.
//               Optional feature macro: LSU_MISALIGN_EXC_EN. When it is
//               defined, misaligned halfword and word accesses are trapped
//               without touching the bus. When it is undefined, exc_misalign
//               is tied low and the low address bits are ignored.
// Ports       : clk, rst_n                     clock, async active-low reset
//               req_valid, op, addr, wdata     MEM-stage instruction
//               stall, done, rdata             pipeline control / result
//               exc_misalign, exc_bus          exceptions (valid with done)
//               mem_req/we/be/addr/wdata       request channel
//               mem_gnt, mem_rvalid, mem_rdata response channel
// Revision    : 1.0  initial release
// ============================================================================
module lsu_mem_master #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc_misalign,
    output logic        exc_bus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // The counter value seen in the last REQ/WAIT cycle before the timeout.
    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    state_t      state, next_state;
    logic [3:0]  op_q;        // op[3]=store, op[2]=unsigned, op[1:0]=size
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  cnt;
    logic        bus_q;
    logic        is_mem_op;
    logic        start;
    logic        misalign_in;
    logic        timeout;
    logic [31:0] load_fmt;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Only the eight listed opcodes are memory operations.
    always_comb begin
        case (op)
            6'b100000, 6'b100100, 6'b100001, 6'b100101,
            6'b100011, 6'b101000, 6'b101001, 6'b101011: is_mem_op = 1'b1;
            default:                                    is_mem_op = 1'b0;
        endcase
    end

    assign start   = (state == IDLE) && req_valid && is_mem_op;
    assign timeout = (cnt == CNT_LAST);

`ifdef LSU_MISALIGN_EXC_EN
    logic mis_q;
    // op[1:0]: 01 = halfword, 11 = word; bytes are never misaligned.
    assign misalign_in  = ((op[1:0] == 2'b01) && addr[0]) ||
                          ((op[1:0] == 2'b11) && (addr[1:0] != 2'b00));
    assign exc_misalign = done & mis_q;
`else
    assign misalign_in  = 1'b0;
    assign exc_misalign = 1'b0;
`endif

    assign exc_bus = done & bus_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        done       = 1'b0;
        mem_req    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stall      = 1'b1;
                    next_state = misalign_in ? RESP : REQ;
                end
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (timeout) begin
                    next_state = RESP;
                end else if (mem_gnt) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                // A response arriving on the last allowed cycle still wins.
                if (mem_rvalid || timeout) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Load lane selection and extension.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_lane = mem_rdata[7:0];
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q[1:0])
            2'b00:   load_fmt = {{24{byte_lane[7] & ~op_q[2]}}, byte_lane};
            2'b01:   load_fmt = {{16{half_lane[15] & ~op_q[2]}}, half_lane};
            default: load_fmt = mem_rdata;
        endcase
    end

    // Latched access fields, timeout counter, result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            cnt     <= 8'd0;
            bus_q   <= 1'b0;
            rdata   <= 32'd0;
`ifdef LSU_MISALIGN_EXC_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            // REQ is only entered from IDLE, so clearing in IDLE clears on entry.
            if (state == IDLE) begin
                cnt <= 8'd0;
            end else if ((state == REQ) || (state == WAIT)) begin
                cnt <= cnt + 8'd1;
            end

            if (start) begin
                op_q    <= op[3:0];
                addr_q  <= addr;
                wdata_q <= wdata;
                bus_q   <= 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
                mis_q   <= misalign_in;
`endif
                if (misalign_in) begin
                    rdata <= 32'd0;
                end
            end

            if ((state == WAIT) && mem_rvalid) begin
                rdata <= op_q[3] ? 32'd0 : load_fmt;
            end else if (((state == REQ) || (state == WAIT)) && timeout) begin
                bus_q <= 1'b1;
                rdata <= 32'd0;
            end
        end
    end

    // Request channel: driven only while a request is outstanding.
    always_comb begin
        mem_addr  = 32'd0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = 32'd0;
        if (mem_req) begin
            mem_addr = {addr_q[31:2], 2'b00};
            mem_we   = op_q[3];
            mem_be   = 4'b1111;
            if (op_q[3]) begin
                case (op_q[1:0])
                    2'b00: begin
                        mem_be    = 4'b0001 << addr_q[1:0];
                        mem_wdata = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                        mem_wdata = {2{wdata_q[15:0]}};
                    end
                    default: mem_wdata = wdata_q;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
